// File: rtl/regfile_wb_pkg.sv
// Shared widths and the queue entry type for the register-file write-back front end.
package regfile_wb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back result queue: one push and one pop per cycle, with per-entry {valid, rd}
// exported so the top level can run the scoreboard compare.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push_i,
  input  wb_entry_t                       push_entry_i,
  input  logic                            pop_i,
  output logic                            full_o,
  output logic                            empty_o,
  output wb_entry_t                       head_o,
  output logic [DEPTH-1:0]                valid_o,
  output logic [DEPTH-1:0][REG_W-1:0]     rd_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = valid_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) rd_o[i] = mem_q[i].rd;
  end

  // Pointers are exactly PTR_W bits wide, so wrap modulo DEPTH is free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop_ok) begin
      rd_ptr_d          = rd_ptr_q + 1'b1;
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (push_ok) begin
      wr_ptr_d          = wr_ptr_q + 1'b1;
      valid_d[wr_ptr_q] = 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side front end for RegFile: MEM>ALU arbitration, x0 filtering, queued writes and
// busy scoreboard. Optional same-cycle bypass on an empty queue under RFWB_BYPASS_EN.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [REG_W-1:0]  WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  input  logic [REG_W-1:0]  ReadReg1,
  input  logic [REG_W-1:0]  ReadReg2,
  output logic              busy1,
  output logic              busy2
);

  logic                        full, empty;
  logic                        accept, in_live, bypass, push;
  wb_entry_t                   in_entry, head;
  logic [DEPTH-1:0]            ent_valid;
  logic [DEPTH-1:0][REG_W-1:0] ent_rd;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (in_entry),
    .pop_i        (!empty),
    .full_o       (full),
    .empty_o      (empty),
    .head_o       (head),
    .valid_o      (ent_valid),
    .rd_o         (ent_rd)
  );

  // Ready depends only on full: a same-cycle pop never frees a slot for the push.
  assign mem_ready = !reset && !full;
  assign alu_ready = !reset && !full && !mem_valid;

  assign in_entry = mem_valid ? wb_entry_t'{rd: mem_rd, data: mem_data}
                              : wb_entry_t'{rd: alu_rd, data: alu_data};
  assign accept   = !reset && !full && (mem_valid || alu_valid);
  assign in_live  = accept && (in_entry.rd != '0);

`ifdef RFWB_BYPASS_EN
  assign bypass = in_live && empty;
`else
  assign bypass = 1'b0;
`endif
  assign push = in_live && !bypass;

  always_comb begin
    RegWrite  = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    if (!reset) begin
      if (!empty) begin
        RegWrite  = 1'b1;
        WriteReg  = head.rd;
        WriteData = head.data;
      end else if (bypass) begin
        RegWrite  = 1'b1;
        WriteReg  = in_entry.rd;
        WriteData = in_entry.data;
      end
    end
  end

  // The entry popped this cycle still counts; the incoming push does not.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == ReadReg1)) busy1 = 1'b1;
      if (ent_valid[i] && (ent_rd[i] == ReadReg2)) busy2 = 1'b1;
    end
    if (reset || (ReadReg1 == '0)) busy1 = 1'b0;
    if (reset || (ReadReg2 == '0)) busy2 = 1'b0;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: vector table with per-cycle expectations plus a write scoreboard.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd = '0, mem_rd = '0, ReadReg1 = '0, ReadReg2 = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite, busy1, busy2;

  always #5 clk = ~clk;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .busy1(busy1), .busy2(busy2)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic        rst, av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic [4:0]  r1, r2;
    logic        ar, mr, rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        b1, b2;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[19];
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_writes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      input logic [4:0] r1, input logic [4:0] r2);
    sb_t         e;
    logic        full_e, acc, b1, b2;
    logic [4:0]  in_rd;
    logic [31:0] in_d;
    @(posedge clk);
    #1;
    reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md; ReadReg1 = r1; ReadReg2 = r2;
    @(negedge clk);
    full_e = (sb.size() >= DEPTH);
    b1 = 1'b0;
    b2 = 1'b0;
    foreach (sb[i]) begin
      if (sb[i].rd == r1) b1 = 1'b1;
      if (sb[i].rd == r2) b2 = 1'b1;
    end
    if (rst || r1 == 5'd0) b1 = 1'b0;
    if (rst || r2 == 5'd0) b2 = 1'b0;
    chk("mem_ready", 32'(mem_ready), 32'(!rst && !full_e));
    chk("alu_ready", 32'(alu_ready), 32'(!rst && !full_e && !mv));
    chk("busy1", 32'(busy1), 32'(b1));
    chk("busy2", 32'(busy2), 32'(b2));
    acc   = !rst && !full_e && (av || mv);
    in_rd = mv ? mrd : ard;
    in_d  = mv ? md : ad;
    if (in_rd == 5'd0) acc = 1'b0;
`ifdef RFWB_BYPASS_EN
    if (acc && sb.size() == 0) begin
      sb.push_back('{in_rd, in_d});
      acc = 1'b0;
    end
`endif
    if (RegWrite === 1'b1) n_writes++;
    if (rst || sb.size() == 0) begin
      chk("regwrite_idle", 32'(RegWrite), 32'd0);
      chk("writereg_idle", 32'(WriteReg), 32'd0);
      chk("writedata_idle", WriteData, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("regwrite", 32'(RegWrite), 32'd1);
      chk("writereg", 32'(WriteReg), 32'(e.rd));
      chk("writedata", WriteData, e.data);
    end
    if (rst) sb.delete();
    else if (acc) sb.push_back('{in_rd, in_d});
  endtask

  initial begin
    int w0;
    //         rst   av    ard    ad             mv    mrd    md         r1     r2     ar    mr    rw    wr     wd             b1    b2
    tbl[0]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,     5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,     5'd5,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd5,  5'd0,  1'b1, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF,  1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd5,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,    5'd3,  5'd4,  1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 5'd3,  32'h11,       1'b0, 5'd0,  32'h0,     5'd3,  5'd4,  1'b1, 1'b1, 1'b1, 5'd4,  32'h22,        1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd3,  5'd4,  1'b1, 1'b1, 1'b1, 5'd3,  32'h11,        1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd3,  5'd4,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,     5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 5'd7,  32'hA,        1'b0, 5'd0,  32'h0,     5'd7,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 5'd7,  32'hB,        1'b0, 5'd0,  32'h0,     5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 5'd7,  32'hA,         1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 5'd7,  32'hB,         1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd7,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 5'd10, 32'h1010,     1'b1, 5'd9,  32'h99,    5'd9,  5'd10, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 5'd10, 32'h1010,     1'b1, 5'd0,  32'h0,     5'd9,  5'd10, 1'b0, 1'b1, 1'b1, 5'd9,  32'h99,        1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 5'd10, 32'h1010,     1'b0, 5'd0,  32'h0,     5'd9,  5'd10, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd9,  5'd10, 1'b1, 1'b1, 1'b1, 5'd10, 32'h1010,      1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd9,  5'd10, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd, tbl[i].md,
           tbl[i].r1, tbl[i].r2);
`ifndef RFWB_BYPASS_EN
      chk($sformatf("tbl%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].ar));
      chk($sformatf("tbl%0d_mem_ready", i), 32'(mem_ready), 32'(tbl[i].mr));
      chk($sformatf("tbl%0d_regwrite", i), 32'(RegWrite), 32'(tbl[i].rw));
      chk($sformatf("tbl%0d_writereg", i), 32'(WriteReg), 32'(tbl[i].wr));
      chk($sformatf("tbl%0d_writedata", i), WriteData, tbl[i].wd);
      chk($sformatf("tbl%0d_busy1", i), 32'(busy1), 32'(tbl[i].b1));
      chk($sformatf("tbl%0d_busy2", i), 32'(busy2), 32'(tbl[i].b2));
`endif
    end

    // Sustained ALU stream: eight contiguous writes in order.
    w0 = n_writes;
    for (int i = 1; i <= 8; i++)
      step(1'b0, 1'b1, 5'(i), 32'(i) * 32'h111, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i - 1));
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd0);
    chk("stream_writes", 32'(n_writes - w0), 32'd8);

    // Reset with an entry in flight: no stale write afterwards.
    step(1'b0, 1'b1, 5'd12, 32'hC, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0);
    step(1'b1, 1'b1, 5'd13, 32'hD, 1'b1, 5'd14, 32'hE, 5'd12, 5'd13);
    w0 = n_writes;
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd13);
    chk("no_stale_writes", 32'(n_writes - w0), 32'd0);

    // Random mixed traffic with both sources contending.
    for (int i = 0; i < 40; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
